// File: rtl/uart_host_pkg.sv
// Shared definitions for the CoreUART host: FSM state encoding, grant
// encoding, rx_err bit positions and the error-counter ceiling.
`timescale 1ns/1ps
package uart_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_TX = 1'b0,
    GNT_RX = 1'b1
  } grant_e;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_OVF = 2;

  localparam logic [7:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_host_errcnt.sv
// One 8-bit saturating event counter with synchronous clear.
// Clear has priority over a same-cycle increment.
`timescale 1ns/1ps
module uart_host_errcnt
  import uart_host_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins, otherwise increment until the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != ERRCNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_core_host.sv
// Host (initiator) side of the CoreUART CSN/WEN/OEN register port.
// Moves bytes from a valid/ready TX stream into the core and drains
// received bytes plus {overflow, framing, parity} into a valid/ready RX
// stream. One transfer per 2+HOLDOFF cycles; HOLDOFF covers the core's
// registered TXRDY/RXRDY lag after a strobe.
// Optional build macro UART_HOST_ERRCNT_EN adds err_clr/err_cnt and three
// saturating per-flag error counters.
`timescale 1ns/1ps
module uart_core_host
  import uart_host_pkg::*;
#(
  parameter int HOLDOFF  = 2,
  parameter int ARB_MODE = 0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic [2:0]  rx_err,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        uart_csn,
  output logic        uart_wen,
  output logic        uart_oen,
  output logic [7:0]  uart_din,
  input  logic [7:0]  uart_dout,
  input  logic        uart_txrdy,
  input  logic        uart_rxrdy,
  input  logic        uart_perr,
  input  logic        uart_ferr,
  input  logic        uart_ovf
`ifdef UART_HOST_ERRCNT_EN
  ,
  input  logic        err_clr,
  output logic [23:0] err_cnt
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

  state_e     state_q,      state_d;
  logic [3:0] hold_cnt_q,   hold_cnt_d;
  grant_e     last_grant_q, last_grant_d;
  logic       csn_q,        csn_d;
  logic       wen_q,        wen_d;
  logic       oen_q,        oen_d;
  logic [7:0] din_q,        din_d;
  logic [7:0] rx_data_q,    rx_data_d;
  logic [2:0] rx_err_q,     rx_err_d;
  logic       rx_valid_q,   rx_valid_d;
  // run_q is low while in reset and for the first cycle after release so
  // that the combinational accept pulse is quiet during reset.
  logic       run_q;

  logic rd_req;
  logic wr_req;
  logic grant_rd;
  logic grant_wr;

  // Request qualification and RX/TX arbitration for the IDLE decision.
  always_comb begin
    rd_req   = run_q & uart_rxrdy & ~rx_valid_q;
    wr_req   = run_q & uart_txrdy & tx_valid;
    grant_rd = rd_req;
    if (rd_req && wr_req) begin
      grant_rd = (ARB_MODE == 1) ? 1'b1 : (last_grant_q == GNT_TX);
    end
    grant_wr = wr_req & ~grant_rd;
  end

  // FSM next-state, strobe and RX-capture computation; strobes default high
  // every cycle so none can last longer than one cycle.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    csn_d        = 1'b1;
    wen_d        = 1'b1;
    oen_d        = 1'b1;
    din_d        = din_q;
    rx_data_d    = rx_data_q;
    rx_err_d     = rx_err_q;
    rx_valid_d   = rx_valid_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d = ST_READ;
          csn_d   = 1'b0;
          oen_d   = 1'b0;
        end else if (grant_wr) begin
          state_d = ST_WRITE;
          csn_d   = 1'b0;
          wen_d   = 1'b0;
          din_d   = tx_data;
        end
      end
      ST_WRITE: begin
        last_grant_d = GNT_TX;
        hold_cnt_d   = '0;
        state_d      = ST_HOLD;
      end
      ST_READ: begin
        rx_data_d         = uart_dout;
        rx_err_d[ERR_OVF] = uart_ovf;
        rx_err_d[ERR_FRM] = uart_ferr;
        rx_err_d[ERR_PAR] = uart_perr;
        rx_valid_d        = 1'b1;
        last_grant_d      = GNT_RX;
        hold_cnt_d        = '0;
        state_d           = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, strobe and RX output registers; async reset drops strobes at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      last_grant_q <= GNT_TX;
      csn_q        <= 1'b1;
      wen_q        <= 1'b1;
      oen_q        <= 1'b1;
      din_q        <= '0;
      rx_data_q    <= '0;
      rx_err_q     <= '0;
      rx_valid_q   <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      csn_q        <= csn_d;
      wen_q        <= wen_d;
      oen_q        <= oen_d;
      din_q        <= din_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      rx_valid_q   <= rx_valid_d;
      run_q        <= 1'b1;
    end
  end

  // The accept pulse is the only combinational output: it must coincide
  // with the edge that latches tx_data into uart_din.
  assign tx_ready = (state_q == ST_IDLE) & grant_wr;

  assign uart_csn = csn_q;
  assign uart_wen = wen_q;
  assign uart_oen = oen_q;
  assign uart_din = din_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign rx_valid = rx_valid_q;

`ifdef UART_HOST_ERRCNT_EN
  logic       rd_cap;
  logic [7:0] cnt_ovf;
  logic [7:0] cnt_frm;
  logic [7:0] cnt_par;

  assign rd_cap = (state_q == ST_READ);

  uart_host_errcnt u_cnt_ovf (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (rd_cap & uart_ovf),
    .clr     (err_clr),
    .cnt     (cnt_ovf)
  );

  uart_host_errcnt u_cnt_frm (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (rd_cap & uart_ferr),
    .clr     (err_clr),
    .cnt     (cnt_frm)
  );

  uart_host_errcnt u_cnt_par (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (rd_cap & uart_perr),
    .clr     (err_clr),
    .cnt     (cnt_par)
  );

  assign err_cnt = {cnt_ovf, cnt_frm, cnt_par};
`endif

endmodule
